// File: rtl/wu_pkg.sv
// Shared wake-up definitions: detector state encoding and the default bit-rate
// and wake-up word constants that the detector and Sync must agree on.
package wu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        ARMED   = 2'd2,
        HANDOFF = 2'd3
    } wu_state_t;

    localparam int unsigned BIT_CYC_DEF     = 100;
    localparam int unsigned PAT_LEN_DEF     = 16;
    localparam logic [15:0] WU_PATTERN_DEF  = 16'hB38F;
    localparam int unsigned ARM_TIMEOUT_DEF = 200000;

endpackage

// File: rtl/edge_sync3.sv
// Three-flop synchroniser for an asynchronous input, with a rising-edge flag
// taken between the two oldest stages.
module edge_sync3 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign q_o    = sync_q[2];
    assign rise_o = (sync_q[2:1] == 2'b01);

endmodule

// File: rtl/wakeup_detector.sv
// On-off-keyed wake-up word detector: hunts for the word on the comparator
// output, arms Sync on an exact match and releases on handoff or timeout.
module wakeup_detector
    import wu_pkg::*;
#(
    parameter int unsigned         BIT_CYC     = BIT_CYC_DEF,
    parameter int unsigned         PAT_LEN     = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0]  WU_PATTERN  = PAT_LEN'(WU_PATTERN_DEF),
    parameter int unsigned         ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
    input  logic       clki,
    input  logic       rst_n,
    input  logic       comp_out,
    input  logic       data_clk_enb,
    output logic       WU_valid,
    output logic       wu_miss,
    output logic [1:0] wu_state
);

    localparam int unsigned PH_W = $clog2(BIT_CYC);
    localparam int unsigned BC_W = $clog2(PAT_LEN + 1);
    localparam int unsigned TM_W = $clog2(ARM_TIMEOUT);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(BIT_CYC / 2 - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(PAT_LEN);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(ARM_TIMEOUT - 1);

    wu_state_t          state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PAT_LEN-1:0] shreg_q, shreg_d;
    logic [TM_W-1:0]    timer_q, timer_d;
    logic               valid_q, valid_d;
    logic               miss_q, miss_d;
    logic               rise, sample;
    logic               word_done;

    edge_sync3 u_sync (
        .clk_i  (clki),
        .rst_ni (rst_n),
        .d_i    (comp_out),
        .q_o    (sample),
        .rise_o (rise)
    );

    assign word_done = (bit_cnt_q == BC_FULL);

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            miss_q    <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HUNT;
            HUNT:    if (word_done) state_d = (shreg_q == WU_PATTERN) ? ARMED : IDLE;
            ARMED: begin
                // Handoff takes priority over a simultaneous timeout.
                if (data_clk_enb)           state_d = HANDOFF;
                else if (timer_q == TM_LAST) state_d = IDLE;
            end
            HANDOFF: if (!data_clk_enb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        timer_d   = timer_q;
        valid_d   = 1'b0;
        miss_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            HUNT: begin
                // A comparator rise marks a bit boundary and re-aligns the bit clock.
                if (rise || phase_q == PH_LAST) phase_d = '0;
                else                            phase_d = phase_q + PH_W'(1);
                if (phase_q == PH_MID && !word_done) begin
                    shreg_d   = {shreg_q[PAT_LEN-2:0], sample};
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
                if (state_d == ARMED) begin
                    valid_d = 1'b1;
                    timer_d = '0;
                end
                miss_d = word_done && (state_d == IDLE);
            end
            ARMED: begin
                timer_d = timer_q + TM_W'(1);
                valid_d = (state_d == ARMED);
            end
            default: ;
        endcase
    end

    assign WU_valid = valid_q;
    assign wu_miss  = miss_q;
    assign wu_state = state_q;

endmodule

// File: tb/tb_wakeup_detector.sv
// Randomised self-checking bench for wakeup_detector: expected detection times
// come from the bit-timing rules (re-alignment on the last rise of the word).
module tb_wakeup_detector;

    localparam int          BIT_CYC = 100;
    localparam int          PAT_LEN = 16;
    localparam logic [15:0] PAT     = 16'hB38F;
    localparam int          TMO     = 3000;

    logic       clki = 1'b0;
    logic       rst_n = 1'b0;
    logic       comp_out = 1'b0;
    logic       data_clk_enb = 1'b0;
    logic       WU_valid;
    logic       wu_miss;
    logic [1:0] wu_state;

    wakeup_detector #(
        .BIT_CYC     (BIT_CYC),
        .PAT_LEN     (PAT_LEN),
        .WU_PATTERN  (PAT),
        .ARM_TIMEOUT (TMO)
    ) dut (
        .clki         (clki),
        .rst_n        (rst_n),
        .comp_out     (comp_out),
        .data_clk_enb (data_clk_enb),
        .WU_valid     (WU_valid),
        .wu_miss      (wu_miss),
        .wu_state     (wu_state)
    );

    always #5 clki = ~clki;

    int cyc = 0;
    always @(posedge clki) cyc <= cyc + 1;

    int   rise_cnt = 0, fall_cnt = 0, miss_cnt = 0;
    int   last_rise = -1, last_fall = -1, last_miss = -1;
    logic v_prev = 1'b0;
    always @(negedge clki) begin
        if (WU_valid && !v_prev) begin rise_cnt <= rise_cnt + 1; last_rise <= cyc; end
        if (!WU_valid && v_prev) begin fall_cnt <= fall_cnt + 1; last_fall <= cyc; end
        if (wu_miss)             begin miss_cnt <= miss_cnt + 1; last_miss <= cyc; end
        v_prev <= WU_valid;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    // Drives a word MSB-first; returns the cycle at which the verdict should
    // appear: half a bit plus pipeline after the last bit, timed from the last rise.
    task automatic drive_word(input logic [15:0] w, input bit jit, input int maxc,
                              output int exp_cyc);
        int b[17];
        int d, m, k;
        d = cyc;
        b[0] = 0;
        for (int i = 1; i < PAT_LEN; i++)
            b[i] = i * BIT_CYC + (jit ? int'($urandom_range(40)) - 20 : 0);
        b[PAT_LEN] = PAT_LEN * BIT_CYC;
        m = 0;
        for (int i = 1; i < PAT_LEN; i++)
            if (w[15-i] && !w[16-i]) m = i;
        exp_cyc = d + 1 + b[m] + BIT_CYC * (PAT_LEN - 1 - m) + BIT_CYC / 2 + 3;
        k = 0;
        for (int c = 0; c < b[PAT_LEN] && c < maxc; c++) begin
            while (k < PAT_LEN - 1 && c >= b[k+1]) k++;
            comp_out = w[15-k];
            tick(1);
        end
        comp_out = 1'b0;
    endtask

    task automatic run_word(input logic [15:0] w, input bit jit);
        int r0, m0, e;
        r0 = rise_cnt;
        m0 = miss_cnt;
        drive_word(w, jit, 1 << 20, e);
        tick(2);
        if (w == PAT) begin
            chk("match_rise_cnt", rise_cnt - r0, 1);
            chk("match_cycle", last_rise, e);
            chk("match_no_miss", miss_cnt - m0, 0);
            chk("match_state", wu_state, 2);
        end else begin
            chk("miss_cnt", miss_cnt - m0, 1);
            chk("miss_cycle", last_miss, e);
            chk("miss_no_valid", rise_cnt - r0, 0);
            chk("miss_state", wu_state, 0);
        end
    endtask

    task automatic handoff(input int delay, input int hold);
        int x, r0;
        tick(delay);
        data_clk_enb = 1'b1;
        x = cyc;
        chk("pre_handoff_valid", WU_valid, 1);
        tick(1);
        chk("handoff_valid", WU_valid, 0);
        chk("handoff_state", wu_state, 3);
        r0 = rise_cnt;
        for (int i = 0; i < hold; i++) begin
            comp_out = 1'($urandom);
            tick(1);
        end
        comp_out = 1'b0;
        tick(4);
        chk("handoff_fall_cycle", last_fall, x + 1);
        chk("handoff_no_retrigger", rise_cnt - r0, 0);
        chk("handoff_hold_state", wu_state, 3);
        data_clk_enb = 1'b0;
        tick(1);
        chk("handoff_release_state", wu_state, 0);
        tick(4);
    endtask

    initial begin
        int r;
        logic [15:0] w;

        for (int i = 0; i < 5; i++) begin
            comp_out = ~comp_out;
            tick(1);
            chk("rst_valid", WU_valid, 0);
            chk("rst_state", wu_state, 0);
            chk("rst_miss", wu_miss, 0);
        end
        comp_out = 1'b0;
        rst_n = 1'b1;
        while (cyc < 9) tick(1);

        run_word(PAT, 1'b0);
        handoff(500, 300);

        run_word(16'hB38E, 1'b0);
        tick(5);
        run_word(PAT, 1'b0);
        handoff(20, 50);

        run_word(PAT, 1'b1);
        handoff(10, 10);

        run_word(PAT, 1'b0);
        r = last_rise;
        while (cyc < r + TMO - 1) tick(1);
        chk("timeout_still_valid", WU_valid, 1);
        tick(1);
        chk("timeout_valid", WU_valid, 0);
        chk("timeout_state", wu_state, 0);
        tick(5);

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(2))
                0:       w = PAT;
                1:       w = PAT ^ (16'h0001 << $urandom_range(14));
                default: w = 16'($urandom) | 16'h8000;
            endcase
            run_word(w, 1'($urandom));
            if (w == PAT) handoff(int'($urandom_range(800)) + 1, int'($urandom_range(30)));
            tick(int'($urandom_range(17)) + 3);
        end

        begin
            int e;
            drive_word(PAT, 1'b0, 500, e);
            chk("mid_hunt_state", wu_state, 1);
            rst_n = 1'b0;
            tick(1);
            chk("hunt_rst_state", wu_state, 0);
            chk("hunt_rst_valid", WU_valid, 0);
            rst_n = 1'b1;
            tick(5);
        end

        run_word(PAT, 1'b0);
        tick(100);
        rst_n = 1'b0;
        tick(1);
        chk("armed_rst_valid", WU_valid, 0);
        chk("armed_rst_state", wu_state, 0);
        rst_n = 1'b1;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
